// File: rtl/obi_mem_responder.sv
// rtl/obi_mem_responder.sv - OBI data-memory responder: byte-enable SRAM, fixed response latency, outstanding limit, grant stall
// Optional feature macro: OBI_MEM_ERR_EN (error response and write suppression for addresses beyond MEM_WORDS)
module obi_mem_responder #(
  parameter int MEM_WORDS       = 1024,
  parameter int LATENCY         = 1,
  parameter int MAX_OUTSTANDING = 2,
  parameter int GNT_STALL       = 0
) (
  input  logic        clk,
  input  logic        n_reset,
  input  logic        data_req_i,
  output logic        data_gnt_o,
  input  logic [31:0] data_addr_i,
  input  logic        data_we_i,
  input  logic [3:0]  data_be_i,
  input  logic [31:0] data_wdata_i,
  output logic        data_rvalid_o,
  output logic [31:0] data_rdata_o
`ifdef OBI_MEM_ERR_EN
  ,
  output logic        data_err_o
`endif
);

  localparam int AW = $clog2(MEM_WORDS);

  logic [AW-1:0]      word_idx;
  logic               addr_err;
  logic               accept;
  logic               resp_done;
  logic [31:0]        mem_word;
  logic [31:0]        resp_rdata;
  logic [2:0]         stall_cnt;
  logic [2:0]         outstanding;
  logic [LATENCY-1:0] pipe_valid;
  logic [31:0]        pipe_rdata [LATENCY];
  logic               unused_addr;

  // Upper bits wrap silently unless the error feature is built in.
  assign word_idx = data_addr_i[AW+1:2];
`ifdef OBI_MEM_ERR_EN
  assign addr_err    = |data_addr_i[31:AW+2];
  assign unused_addr = ^data_addr_i[1:0];
`else
  assign addr_err    = 1'b0;
  assign unused_addr = ^{data_addr_i[31:AW+2], data_addr_i[1:0]};
`endif

  assign resp_done  = pipe_valid[LATENCY-1];
  // A retiring response frees its slot in the same cycle, so full throughput holds at the limit.
  assign data_gnt_o = data_req_i && (stall_cnt == 3'(GNT_STALL)) &&
                      ((outstanding < 3'(MAX_OUTSTANDING)) || resp_done);
  assign accept     = data_req_i && data_gnt_o;

  // One byte lane per generate iteration keeps each lane array single-driven.
  for (genvar n = 0; n < 4; n++) begin : g_lane
    logic [7:0] lane [MEM_WORDS];

    // Byte-lane write on acceptance; memory contents survive reset.
    always_ff @(posedge clk) begin
      if (accept && data_we_i && !addr_err && data_be_i[n]) begin
        lane[word_idx] <= data_wdata_i[8*n +: 8];
      end
    end

    assign mem_word[8*n +: 8] = lane[word_idx];
  end

  // Reads see the memory before this edge's write; writes and errors answer with zero data.
  assign resp_rdata = (data_we_i || addr_err) ? 32'd0 : mem_word;

  // Consecutive request cycles since the last acceptance, saturating at GNT_STALL.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      stall_cnt <= 3'd0;
    end else if (!data_req_i || accept) begin
      stall_cnt <= 3'd0;
    end else if (stall_cnt != 3'(GNT_STALL)) begin
      stall_cnt <= stall_cnt + 3'd1;
    end
  end

  // Granted-but-unresponded count; simultaneous accept and retire cancel out.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      outstanding <= 3'd0;
    end else if (accept && !resp_done) begin
      outstanding <= outstanding + 3'd1;
    end else if (!accept && resp_done) begin
      outstanding <= outstanding - 3'd1;
    end
  end

  // First response stage loads on acceptance; data holds when nothing is accepted.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pipe_valid[0] <= 1'b0;
      pipe_rdata[0] <= 32'd0;
    end else begin
      pipe_valid[0] <= accept;
      if (accept) begin
        pipe_rdata[0] <= resp_rdata;
      end
    end
  end

  for (genvar k = 1; k < LATENCY; k++) begin : g_pipe
    // Later stages advance data only behind a valid entry, so the output holds between pulses.
    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        pipe_valid[k] <= 1'b0;
        pipe_rdata[k] <= 32'd0;
      end else begin
        pipe_valid[k] <= pipe_valid[k-1];
        if (pipe_valid[k-1]) begin
          pipe_rdata[k] <= pipe_rdata[k-1];
        end
      end
    end
  end

  assign data_rvalid_o = resp_done;
  assign data_rdata_o  = pipe_rdata[LATENCY-1];

`ifdef OBI_MEM_ERR_EN
  logic [LATENCY-1:0] pipe_err;

  // Error flag travels alongside the response it belongs to.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      pipe_err[0] <= 1'b0;
    end else if (accept) begin
      pipe_err[0] <= addr_err;
    end
  end

  for (genvar k = 1; k < LATENCY; k++) begin : g_err
    // Error stage shift mirrors the data stages.
    always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
        pipe_err[k] <= 1'b0;
      end else if (pipe_valid[k-1]) begin
        pipe_err[k] <= pipe_err[k-1];
      end
    end
  end

  assign data_err_o = pipe_err[LATENCY-1];
`endif

endmodule

// File: tb/tb_obi_mem_responder.sv
// tb/tb_obi_mem_responder.sv - randomized bench for obi_mem_responder against a queue-based reference model
module tb_obi_mem_responder;

  localparam int MEM_WORDS = 64;
  localparam int LAT       = 3;
  localparam int MAX_OUT   = 1;
  localparam int STALL     = 1;

  logic        clk;
  logic        n_reset;
  logic        data_req_i;
  logic        data_gnt_o;
  logic [31:0] data_addr_i;
  logic        data_we_i;
  logic [3:0]  data_be_i;
  logic [31:0] data_wdata_i;
  logic        data_rvalid_o;
  logic [31:0] data_rdata_o;
`ifdef OBI_MEM_ERR_EN
  logic        data_err_o;
`endif

  obi_mem_responder #(
    .MEM_WORDS      (MEM_WORDS),
    .LATENCY        (LAT),
    .MAX_OUTSTANDING(MAX_OUT),
    .GNT_STALL      (STALL)
  ) dut (
    .clk          (clk),
    .n_reset      (n_reset),
    .data_req_i   (data_req_i),
    .data_gnt_o   (data_gnt_o),
    .data_addr_i  (data_addr_i),
    .data_we_i    (data_we_i),
    .data_be_i    (data_be_i),
    .data_wdata_i (data_wdata_i),
    .data_rvalid_o(data_rvalid_o),
    .data_rdata_o (data_rdata_o)
`ifdef OBI_MEM_ERR_EN
    ,
    .data_err_o   (data_err_o)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int unsigned due;
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  rsp_t        pq[$];
  logic [31:0] mem_m [MEM_WORDS];
  int unsigned cyc;
  int          stall_run;
  int          n_cmp;
  int          n_mis;
  logic [31:0] last_rdata;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One bus cycle: drive, compare at mid-cycle, then advance the model past the edge.
  task automatic cycle(input logic req, input logic we, input logic [31:0] addr,
                       input logic [3:0] be, input logic [31:0] wd, output logic acc);
    logic        exp_rv;
    logic        exp_gnt;
    logic        oor;
    int unsigned idx;
    rsp_t        r;
    @(posedge clk);
    #1;
    data_req_i   = req;
    data_we_i    = we;
    data_addr_i  = addr;
    data_be_i    = be;
    data_wdata_i = wd;
    @(negedge clk);
    exp_rv  = (pq.size() > 0) && (pq[0].due == cyc);
    exp_gnt = req && (stall_run == STALL) && ((pq.size() < MAX_OUT) || exp_rv);
    check("gnt", {31'd0, data_gnt_o}, {31'd0, exp_gnt});
    check("rvalid", {31'd0, data_rvalid_o}, {31'd0, exp_rv});
    if (data_rvalid_o) last_rdata = data_rdata_o;
    if (exp_rv) begin
      check("rdata", data_rdata_o, pq[0].rdata);
`ifdef OBI_MEM_ERR_EN
      check("err", {31'd0, data_err_o}, {31'd0, pq[0].err});
`endif
      void'(pq.pop_front());
    end
    acc = exp_gnt;
    if (exp_gnt) begin
      idx = (addr >> 2) % MEM_WORDS;
`ifdef OBI_MEM_ERR_EN
      oor = (addr >> 2) >= MEM_WORDS;
`else
      oor = 1'b0;
`endif
      r.due   = cyc + LAT;
      r.err   = oor;
      r.rdata = (we || oor) ? 32'd0 : mem_m[idx];
      pq.push_back(r);
      if (we && !oor) begin
        for (int n = 0; n < 4; n++) begin
          if (be[n]) mem_m[idx][8*n +: 8] = wd[8*n +: 8];
        end
      end
      stall_run = 0;
    end else if (!req) begin
      stall_run = 0;
    end else if (stall_run < STALL) begin
      stall_run++;
    end
    cyc++;
  endtask

  task automatic txn(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
    logic acc;
    int   n;
    n = 0;
    do begin
      cycle(1'b1, we, addr, be, wd, acc);
      n++;
    end while (!acc && n < 20);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 32'd0, 4'd0, 32'd0, acc);
  endtask

  // Reset held for ncyc cycles; all in-flight responses are dropped from the model.
  task automatic apply_reset(input int ncyc);
    @(posedge clk);
    #1;
    n_reset    = 1'b0;
    data_req_i = 1'b0;
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      check("rst_gnt", {31'd0, data_gnt_o}, 32'd0);
      check("rst_rvalid", {31'd0, data_rvalid_o}, 32'd0);
      check("rst_rdata", data_rdata_o, 32'd0);
`ifdef OBI_MEM_ERR_EN
      check("rst_err", {31'd0, data_err_o}, 32'd0);
`endif
      if (i < ncyc - 1) @(posedge clk);
    end
    pq.delete();
    stall_run = 0;
    n_reset   = 1'b1;
  endtask

  initial begin
    logic        acc;
    logic [31:0] a;
    n_cmp = 0;
    n_mis = 0;
    cyc = 0;
    stall_run = 0;
    last_rdata = 32'd0;
    n_reset = 1'b0;
    data_req_i = 1'b0;
    data_we_i = 1'b0;
    data_addr_i = 32'd0;
    data_be_i = 4'd0;
    data_wdata_i = 32'd0;
    apply_reset(2);

    for (int w = 0; w < MEM_WORDS; w++) txn(1'b1, 32'(w * 4), 4'hF, $urandom);
    idle(LAT + 2);

    txn(1'b1, 32'h10, 4'hF, 32'hDEADBEEF);
    txn(1'b0, 32'h10, 4'hF, 32'd0);
    idle(LAT + 2);
    check("read_word4", last_rdata, 32'hDEADBEEF);

    txn(1'b1, 32'h08, 4'hF, 32'h11223344);
    txn(1'b1, 32'h08, 4'b0101, 32'hAABBCCDD);
    txn(1'b0, 32'h08, 4'hF, 32'd0);
    idle(LAT + 2);
    check("be_merge", last_rdata, 32'h11BB33DD);

    txn(1'b0, 32'h08, 4'hF, 32'd0);
    idle(1);
    apply_reset(2);
    idle(LAT + 2);
    txn(1'b0, 32'h10, 4'hF, 32'd0);
    idle(LAT + 2);
    check("post_reset_read", last_rdata, 32'hDEADBEEF);

    txn(1'b1, 32'(MEM_WORDS * 4), 4'hF, 32'h12345678);
    txn(1'b0, 32'(MEM_WORDS * 4), 4'hF, 32'd0);
    txn(1'b0, 32'(MEM_WORDS * 4 - 4), 4'hF, 32'd0);
    txn(1'b0, 32'd0, 4'hF, 32'd0);
    idle(LAT + 2);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        apply_reset(1 + $urandom_range(0, 1));
      end else begin
        if ($urandom_range(0, 7) == 0) a = $urandom;
        else a = 32'($urandom_range(0, MEM_WORDS * 4 - 1));
        cycle($urandom_range(0, 3) != 0, 1'($urandom), a, 4'($urandom), $urandom, acc);
      end
    end
    idle(LAT + 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
